// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO fed by a UART receiver.
// A push is generated on each rising edge of rx_ready (frame done);
// entries carry {rx_error, rx_data}. Pops occur when m_valid && m_ready.
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   rx_ready       - receiver ready level (low while a frame arrives)
//   rx_data        - received character
//   rx_error       - receiver stop/parity error flag
//   m_valid        - head entry available (!empty)
//   m_data/m_error - head entry data and error tag
//   m_ready        - consumer pop request
//   count          - number of stored entries
//   full / empty   - occupancy flags
//   overflow       - sticky: a frame was dropped because the FIFO was full
//   clr_overflow   - synchronous clear of overflow (a coincident drop wins)
//
// Build option: define UART_RX_FIFO_DROP_ERR_EN to discard errored
// frames instead of storing them; m_error is then tied low.

module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_ready,
    input  logic [DATA_BITS-1:0]       rx_data,
    input  logic                       rx_error,
    output logic                       m_valid,
    output logic [DATA_BITS-1:0]       m_data,
    output logic                       m_error,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int AW = $clog2(DEPTH);

`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam int EW = DATA_BITS;
`else
    localparam int EW = DATA_BITS + 1;
`endif

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rdy_q;
    logic          r_overflow;

    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_drop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_head;

    // Rising edge of rx_ready marks the end of a frame. r_rdy_q resets
    // high so the receiver's idle-high ready does not look like an edge.
    assign w_push_req = rx_ready && !r_rdy_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign w_push     = w_push_req && !rx_error;
    assign w_wr_entry = rx_data;
`else
    assign w_push     = w_push_req;
    assign w_wr_entry = {rx_error, rx_data};
`endif

    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && m_ready;

    // When full, a simultaneous pop frees the slot being written
    // (write and read pointers coincide), so the push is accepted.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    assign w_head = r_mem[r_rptr];

    assign m_valid  = !w_empty;
    assign m_data   = w_head[DATA_BITS-1:0];
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign m_error  = 1'b0;
`else
    assign m_error  = w_head[DATA_BITS];
`endif
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_q    <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rdy_q <= rx_ready;

            if (w_wr_en) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end

            unique case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of one received character; must match the receiver's DATA_BITS.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_ready  input  1  receiver ready level: low while a frame is arriving, high when idle or done.
REQ-006 SHALL have port rx_data  input  DATA_BITS  receiver data_out.
REQ-007 SHALL have port rx_error  input  1  receiver stop/parity error flag.
REQ-008 SHALL have port m_valid  output  1  head entry available.
REQ-009 SHALL have port m_data  output  DATA_BITS  head entry data.
REQ-010 SHALL have port m_error  output  1  head entry error tag.
REQ-011 SHALL have port m_ready  input  1  consumer pop request.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port overflow  output  1  sticky flag: a frame was lost.
REQ-016 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-017 SHALL register rx_ready into rdy_q each cycle; a frame-done event (push request) is rx_ready==1 && rdy_q==0 in the same cycle.
REQ-018 SHALL capture {rx_error, rx_data} in the frame-done cycle and write the entry at the clock edge ending that cycle.
REQ-019 SHALL be first-word-fall-through: m_valid = !empty; m_data/m_error show the head entry combinationally from storage; a written entry is visible the cycle after frame-done.
REQ-020 SHALL pop on the rising edge where m_valid && m_ready; m_ready while empty has no effect.
REQ-021 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0 with no special case.
REQ-022 SHALL accept push and pop in the same cycle when not empty: count unchanged, both pointers advance.
REQ-023 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise it drops the frame, leaves storage, pointers and count unchanged, and sets overflow the following cycle.
REQ-024 SHALL treat push while empty with m_ready=1 as push only; the entry is not popped until the next cycle.
REQ-025 SHALL hold overflow high until clr_overflow=1; when a drop and clr_overflow coincide, overflow ends set (set wins).
REQ-026 SHALL generate exactly one push per rx_ready low-to-high transition, regardless of how long rx_ready stays high.

Reset
REQ-027 SHALL on rst=1 asynchronously force: pointers=0, count=0, empty=1, full=0, m_valid=0, overflow=0, rdy_q=1; storage contents are not reset.
REQ-028 SHALL, with rdy_q reset to 1, produce no push from the receiver's idle-high ready after reset release.
REQ-029 SHALL, if rst asserts mid-frame (rx_ready low), produce no push for that frame unless rx_ready is seen low again after release.

Configuration
REQ-030 SHALL honour macro UART_RX_FIFO_DROP_ERR_EN: when defined, a frame-done event with rx_error=1 is discarded (no write, no overflow effect) and m_error is tied 0; when undefined, errored frames are stored with m_error=1.

Verification
REQ-031 Reset release with rx_ready=1 held for 100 cycles -> count=0, m_valid=0, overflow=0.
REQ-032 Three frames 0x41, 0x42, 0x43 with error=0, m_ready=0 -> count=3; then m_ready=1 for 3 cycles -> m_data 0x41, 0x42, 0x43 in order, empty=1.
REQ-033 DEPTH=16: 17 frames with no pops -> full=1, count=16, overflow=1; the 17th value is absent; pop order is frames 1..16.
REQ-034 Full FIFO, frame-done coinciding with pop -> count stays 16, overflow stays 0, the new value is last out.
REQ-035 Frame 0x55 with rx_error=1 -> macro undefined: stored, m_error=1; macro defined: count stays 0.
REQ-036 Overflow set, then clr_overflow=1 for one cycle -> overflow=0 next cycle; clr_overflow during a dropping push -> overflow stays 1.
